// File: rtl/puf_eval_ctrl.sv
// Purpose : sequences one bistable-ring PUF evaluation (shift challenge, reset ring, settle, sample).
// Latency : start accepted at cycle 0 -> resp_valid at cycle N+RESET_CYC+SETTLE_CYC+3 (+ voting rounds).
// Backpressure: none; start is ignored while busy, nothing is queued.
//
// Ports: clk/rstn (sync active-low), start/length/chal request, busy/resp_valid/resp_bit response,
//        puf_si/puf_reset/puf_length drive the PUF, puf_out is the raw asynchronous ring output.
// Optional feature: define MAJORITY_VOTE_EN to run NUM_EVAL evaluations per request and return
//        the majority of the sampled bits instead of a single sample.
module puf_eval_ctrl #(
    parameter int CHAL_W     = 128,
    parameter int RESET_CYC  = 4,
    parameter int SETTLE_CYC = 16,
    parameter int NUM_EVAL   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        length,
    input  logic [CHAL_W-1:0] chal,
    output logic              busy,
    output logic              resp_valid,
    output logic              resp_bit,
    output logic              puf_si,
    output logic              puf_reset,
    output logic [1:0]        puf_length,
    input  logic              puf_out
);

    localparam int CNT_W = $clog2(CHAL_W + RESET_CYC + SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_RST, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CHAL_W-1:0]  shreg_q, shreg_d;
    logic [1:0]         len_q, len_d;
    logic               si_q, si_d;
    logic               rst_q, rst_d;
    logic               rv_q, rv_d;
    logic               rbit_q, rbit_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
`ifdef MAJORITY_VOTE_EN
    logic [3:0]         eval_q, eval_d;
    logic [3:0]         ones_q, ones_d;
`else
    logic               sample_q, sample_d;
`endif

    function automatic logic [CNT_W-1:0] ring_len(input logic [1:0] l);
        case (l)
            2'b00:   return CNT_W'(32);
            2'b01:   return CNT_W'(64);
            default: return CNT_W'(128);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        len_d   = len_q;
        si_d    = 1'b0;
        rst_d   = 1'b1;
        rv_d    = 1'b0;
        rbit_d  = rbit_q;
        sync1_d = puf_out;
        sync2_d = sync1_q;
`ifdef MAJORITY_VOTE_EN
        eval_d  = eval_q;
        ones_d  = ones_q;
`else
        sample_d = sample_q;
`endif
        case (state_q)
            S_IDLE: begin
                // resp_valid_q high means the previous request is still reporting (busy)
                if (start && !rv_q) begin
                    // left-align the low N challenge bits so the MSB shifts out first
                    shreg_d = chal << (CHAL_W - int'(ring_len(length)));
                    len_d   = length;
                    cnt_d   = '0;
`ifdef MAJORITY_VOTE_EN
                    eval_d  = '0;
                    ones_d  = '0;
`endif
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                si_d    = shreg_q[CHAL_W-1];
                shreg_d = shreg_q << 1;
                if (cnt_q == ring_len(len_q) - 1'b1) begin
                    cnt_d   = '0;
                    state_d = S_RST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RST: begin
                if (cnt_q == CNT_W'(RESET_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                rst_d = 1'b0;
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
`ifdef MAJORITY_VOTE_EN
                ones_d = ones_q + {3'b000, sync2_q};
                eval_d = eval_q + 4'd1;
                // re-evaluate with the same shifted challenge; no re-shift needed
                state_d = ((eval_q + 4'd1) < 4'(NUM_EVAL)) ? S_RST : S_DONE;
`else
                sample_d = sync2_q;
                state_d  = S_DONE;
`endif
            end
            S_DONE: begin
                rv_d    = 1'b1;
`ifdef MAJORITY_VOTE_EN
                rbit_d  = (ones_q > 4'(NUM_EVAL / 2));
`else
                rbit_d  = sample_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            len_q   <= 2'b00;
            si_q    <= 1'b0;
            rst_q   <= 1'b1;
            rv_q    <= 1'b0;
            rbit_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
`ifdef MAJORITY_VOTE_EN
            eval_q  <= '0;
            ones_q  <= '0;
`else
            sample_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            len_q   <= len_d;
            si_q    <= si_d;
            rst_q   <= rst_d;
            rv_q    <= rv_d;
            rbit_q  <= rbit_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
`ifdef MAJORITY_VOTE_EN
            eval_q  <= eval_d;
            ones_q  <= ones_d;
`else
            sample_q <= sample_d;
`endif
        end
    end

    // pin outputs are registered one cycle behind the state, so busy also covers the resp cycle
    assign busy       = (state_q != S_IDLE) || rv_q;
    assign resp_valid = rv_q;
    assign resp_bit   = rbit_q;
    assign puf_si     = si_q;
    assign puf_reset  = rst_q;
    assign puf_length = len_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
module tb_puf_eval_ctrl;

    localparam int RC = 4;
    localparam int SC = 16;
`ifdef MAJORITY_VOTE_EN
    localparam int NEV = 5;
`else
    localparam int NEV = 1;
`endif

    logic         clk = 1'b0;
    logic         rstn, start, puf_out;
    logic [1:0]   length;
    logic [127:0] chal;
    logic         busy, resp_valid, resp_bit, puf_si, puf_reset;
    logic [1:0]   puf_length;

    puf_eval_ctrl #(.CHAL_W(128), .RESET_CYC(RC), .SETTLE_CYC(SC), .NUM_EVAL(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .length(length), .chal(chal),
        .busy(busy), .resp_valid(resp_valid), .resp_bit(resp_bit), .puf_si(puf_si),
        .puf_reset(puf_reset), .puf_length(puf_length), .puf_out(puf_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // scoreboard: every response pulse must match a pending request
    always @(negedge clk) begin
        if (rstn === 1'b1 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected resp_valid", 1, 0);
            end else begin
                bit e;
                e = exp_q.pop_front();
                chk("resp_bit", {127'd0, resp_bit}, {127'd0, e});
            end
        end
    end

    typedef struct {
        logic [1:0]   len;
        logic [127:0] chal;
        logic [4:0]   pat;   // ring output per window, first window in bit 4
        int           n;
        bit           hold;  // keep start high and scramble inputs while busy
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int           lat;
        logic [127:0] si_word, mask;
        int           rv_cnt, rv_cyc, low_cnt, win, shift_rst_bad, len_bad;
        logic         prev_rst;
        bit           exp_bit;
        lat = 1 + v.n + RC + SC + 2 + (NEV - 1) * (RC + SC + 1);
        si_word = '0; rv_cnt = 0; rv_cyc = -1; low_cnt = 0; win = 0;
        shift_rst_bad = 0; len_bad = 0; prev_rst = 1'b1;
        mask = (v.n == 128) ? '1 : ((128'd1 << v.n) - 128'd1);
        if (NEV == 1) exp_bit = v.pat[4];
        else          exp_bit = ($countones(v.pat) > NEV / 2);
        length = v.len; chal = v.chal; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp_bit);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("busy after accept", {127'd0, busy}, 1);
                chk("puf_si before shift", {127'd0, puf_si}, 0);
                if (!v.hold) start = 1'b0;
            end
            if (k <= lat && puf_length !== v.len) len_bad++;
            if (k >= 2 && k <= v.n + 1) si_word = {si_word[126:0], puf_si};
            if (k <= v.n + 1 && puf_reset !== 1'b1) shift_rst_bad++;
            if (puf_reset === 1'b0) low_cnt++;
            if (prev_rst && puf_reset === 1'b0) begin
                if (win < 5) puf_out = v.pat[4 - win];
                win++;
            end
            prev_rst = puf_reset;
            if (resp_valid === 1'b1) begin rv_cnt++; rv_cyc = k; end
            if (k == v.n + 2) chk("puf_si after shift", {127'd0, puf_si}, 0);
            if (v.hold && k < lat) begin
                chal   = {$urandom, $urandom, $urandom, $urandom};
                length = 2'($urandom);
            end
            if (k == lat) begin
                start = 1'b0;
                chk("busy at resp", {127'd0, busy}, 1);
            end
            if (k == lat + 1) begin
                chk("busy after resp", {127'd0, busy}, 0);
                chk("resp_bit held", {127'd0, resp_bit}, {127'd0, exp_bit});
            end
        end
        chk("puf_si sequence", si_word, v.chal & mask);
        chk("puf_length stable", len_bad, 0);
        chk("puf_reset high in shift", shift_rst_bad, 0);
        chk("release cycles", low_cnt, NEV * SC);
        chk("release windows", win, NEV);
        chk("resp_valid pulses", rv_cnt, 1);
        chk("resp latency", rv_cyc, lat);
    endtask

    initial begin
        int unexp_busy;
        vecs[0] = '{2'b00, 128'hA5A5_0F0F, 5'b10110, 32, 1'b0};
        vecs[1] = '{2'b11, {$urandom, $urandom, $urandom, $urandom}, 5'b11111, 128, 1'b0};
        vecs[2] = '{2'b01, 128'hDEAD_BEEF_0123_4567, 5'b00101, 64, 1'b0};
        vecs[3] = '{2'b10, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 5'b01110, 128, 1'b0};
        vecs[4] = '{2'b00, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h1234_5678}, 5'b10000, 32, 1'b1};
        vecs[5] = '{2'b01, 128'hC3C3_3C3C_9696_6969, 5'b01011, 64, 1'b0};

        rstn = 1'b0; start = 1'b0; length = 2'b00; chal = '0; puf_out = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {127'd0, busy}, 0);
        chk("reset resp_valid", {127'd0, resp_valid}, 0);
        chk("reset resp_bit", {127'd0, resp_bit}, 0);
        chk("reset puf_si", {127'd0, puf_si}, 0);
        chk("reset puf_reset", {127'd0, puf_reset}, 1);
        chk("reset puf_length", {126'd0, puf_length}, 0);
        rstn = 1'b1;

        // abort mid-shift: no response may ever appear for this request
        @(negedge clk);
        length = 2'b10; chal = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort busy", {127'd0, busy}, 0);
        chk("abort puf_reset", {127'd0, puf_reset}, 1);
        chk("abort puf_si", {127'd0, puf_si}, 0);
        chk("abort puf_length", {126'd0, puf_length}, 0);
        rstn = 1'b1;
        unexp_busy = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) unexp_busy++;
        end
        chk("idle after abort", unexp_busy, 0);

        // back-to-back requests: each new start lands on the cycle after resp_valid
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        repeat (5) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
